// File: rtl/im_pkg.sv
// Shared types and helpers for the instruction-memory port arbiter.
package im_pkg;

  localparam int IM_DEPTH_LOG2 = 10;
  localparam int IM_WORD_W     = 32;

  typedef enum logic {BOOT, RUN} boot_state_t;

  // Byte address to word address; callers keep only the low index bits they need.
  function automatic logic [IM_WORD_W-1:0] word_index(input logic [IM_WORD_W-1:0] addr);
    return {2'b00, addr[IM_WORD_W-1:2]};
  endfunction

endpackage

// File: rtl/im_starve_cnt.sv
// Saturating count of consecutive denied loader cycles; at_max hands the loader priority.
module im_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic at_max
);

  logic [3:0] wait_cnt;

  assign at_max = (wait_cnt == 4'(MAX_WAIT));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset)
      wait_cnt <= '0;
    else if (!req || gnt)
      wait_cnt <= '0;
    else if (!at_max)
      wait_cnt <= wait_cnt + 4'd1;
  end

endmodule

// File: rtl/im_port_arb.sv
// Single-port instruction-memory arbiter between CPU fetch (read) and program loader (write).
// Define IM_BOOT_HOLD_EN to hold fetch off after reset until the loader raises l_done.
module im_port_arb
  import im_pkg::*;
#(
  parameter int DEPTH_LOG2 = IM_DEPTH_LOG2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  l_req,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_gnt,
  input  logic                  l_done,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  logic [31:0]           f_word, l_word;
  logic [DEPTH_LOG2-1:0] f_idx, l_idx, addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic                  rd_pend, at_max, fetch_ok, f_eff;

  assign f_word = word_index(f_addr);
  assign l_word = word_index(l_addr);
  assign f_idx  = f_word[DEPTH_LOG2-1:0];
  assign l_idx  = l_word[DEPTH_LOG2-1:0];

  // Upper address bits wrap by design; l_done only matters with the boot hold.
  logic unused_bits;
  assign unused_bits = ^{f_word[31:DEPTH_LOG2], l_word[31:DEPTH_LOG2], l_done};

`ifdef IM_BOOT_HOLD_EN
  boot_state_t state;

  always_ff @(posedge clk) begin
    if (!reset)
      state <= BOOT;
    else if (state == BOOT && l_done)
      state <= RUN;
  end

  assign fetch_ok = (state == RUN);
`else
  assign fetch_ok = 1'b1;
`endif

  assign f_eff = f_req && fetch_ok;

  im_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .req    (l_req),
    .gnt    (l_gnt),
    .at_max (at_max)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (reset) begin
      if (l_req && f_eff && at_max) l_gnt = 1'b1;
      else if (f_eff)               f_gnt = 1'b1;
      else if (l_req)               l_gnt = 1'b1;
    end
  end

  // Address and data go to memory in the grant cycle so the synchronous read lands next cycle.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (f_gnt) begin
      mem_addr = f_idx;
    end else if (l_gnt) begin
      mem_addr  = l_idx;
      mem_we    = 1'b1;
      mem_wdata = l_wdata;
    end
  end

  // A read pending across a reset edge is dropped rather than returned.
  assign f_rvalid = rd_pend && reset;
  assign f_rdata  = f_rvalid ? mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_pend <= 1'b0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      rdata_q <= f_rdata;
      rd_pend <= f_gnt;
    end
  end

endmodule

// File: tb/tb_im_port_arb.sv
// Directed self-checking bench for im_port_arb with a write-first synchronous memory model.
module tb_im_port_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, l_req, l_done;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, mem_we;
  logic [31:0] f_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  im_port_arb dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .l_req     (l_req),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_done    (l_done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // NOTE: the memory array has no reset; its contents are defined only once written.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; f_req = 1'b1; l_req = 1'b1; l_done = 1'b0;
    f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;

    // Reset held three edges with both requesters active.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_f_gnt", {31'b0, f_gnt}, 32'd0);
      check("rst_l_gnt", {31'b0, l_gnt}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);
    end
    check("rst_f_rdata", f_rdata, 32'h0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

`ifdef IM_BOOT_HOLD_EN
    // Boot hold: only the loader is served until l_done is sampled.
    reset = 1'b1; f_req = 1'b1; f_addr = 32'h100;
    l_req = 1'b1; l_addr = 32'h10; l_wdata = 32'hAAAA0001;
    #1;
    check("boot_w0_f_gnt", {31'b0, f_gnt}, 32'd0);
    check("boot_w0_l_gnt", {31'b0, l_gnt}, 32'd1);
    check("boot_w0_addr", {22'b0, mem_addr}, 32'h4);
    tick();
    l_addr = 32'h14; l_wdata = 32'hAAAA0002;
    #1;
    check("boot_w1_f_gnt", {31'b0, f_gnt}, 32'd0);
    check("boot_w1_l_gnt", {31'b0, l_gnt}, 32'd1);
    tick();
    l_req = 1'b0; l_done = 1'b1;
    #1;
    check("boot_done_f_gnt", {31'b0, f_gnt}, 32'd0);
    tick();
    l_done = 1'b0;
    #1;
    check("boot_run_f_gnt", {31'b0, f_gnt}, 32'd1);
`else
    // Fetch is eligible in the very first cycle after reset release.
    reset = 1'b1; f_req = 1'b1; f_addr = 32'h100; l_req = 1'b0;
    #1;
    check("first_f_gnt", {31'b0, f_gnt}, 32'd1);
    check("first_mem_addr", {22'b0, mem_addr}, 32'h040);
`endif
    tick();
    f_req = 1'b0; l_req = 1'b0;
    tick();

    // Loader write to 0x3000, then fetch of the same word next cycle.
    l_req = 1'b1; l_addr = 32'h00003000; l_wdata = 32'h3C010000;
    #1;
    check("ld_l_gnt", {31'b0, l_gnt}, 32'd1);
    check("ld_mem_we", {31'b0, mem_we}, 32'd1);
    check("ld_mem_addr", {22'b0, mem_addr}, 32'h000);
    check("ld_mem_wdata", mem_wdata, 32'h3C010000);
    tick();
    l_req = 1'b0; f_req = 1'b1; f_addr = 32'h00003000;
    #1;
    check("rd_f_gnt", {31'b0, f_gnt}, 32'd1);
    check("rd_mem_we", {31'b0, mem_we}, 32'd0);
    check("rd_mem_addr", {22'b0, mem_addr}, 32'h000);
    tick();
    f_req = 1'b0;
    #1;
    check("rd_f_rvalid", {31'b0, f_rvalid}, 32'd1);
    check("rd_f_rdata", f_rdata, 32'h3C010000);
    tick();
    check("rd_hold_rvalid", {31'b0, f_rvalid}, 32'd0);
    check("rd_hold_rdata", f_rdata, 32'h3C010000);

    // Byte offset and upper bits are ignored; idle holds the last address.
    f_req = 1'b1; f_addr = 32'h00001007;
    #1;
    check("addr_1007", {22'b0, mem_addr}, 32'h001);
    tick();
    f_addr = 32'h00004004;
    #1;
    check("addr_4004", {22'b0, mem_addr}, 32'h001);
    tick();
    f_addr = 32'h00000008;
    #1;
    check("addr_0008", {22'b0, mem_addr}, 32'h002);
    tick();
    f_req = 1'b0;
    #1;
    check("idle_hold_addr", {22'b0, mem_addr}, 32'h002);
    check("idle_we", {31'b0, mem_we}, 32'd0);
    tick();

    // Contention: fetch wins four cycles, then the loader takes one.
    f_req = 1'b1; f_addr = 32'h100;
    l_req = 1'b1; l_addr = 32'h40; l_wdata = 32'h12345678;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("starve_f_gnt_c%0d", c), {31'b0, f_gnt}, (c == 4 || c == 9) ? 32'd0 : 32'd1);
      check($sformatf("starve_l_gnt_c%0d", c), {31'b0, l_gnt}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
      tick();
    end
    l_req = 1'b0; f_addr = 32'h40;
    #1;
    check("starve_rb_gnt", {31'b0, f_gnt}, 32'd1);
    tick();
    f_req = 1'b0;
    #1;
    check("starve_rb_data", f_rdata, 32'h12345678);
    tick();

    // Reset asserted while a read is pending suppresses f_rvalid.
    f_req = 1'b1; f_addr = 32'h00003000;
    #1;
    check("mid_f_gnt", {31'b0, f_gnt}, 32'd1);
    tick();
    reset = 1'b0; f_req = 1'b0;
    #1;
    check("mid_rvalid_0", {31'b0, f_rvalid}, 32'd0);
    tick();
    check("mid_rvalid_1", {31'b0, f_rvalid}, 32'd0);
    check("mid_rdata", f_rdata, 32'h0);
    reset = 1'b1;
    #1;
    check("mid_rvalid_2", {31'b0, f_rvalid}, 32'd0);
    tick();
    check("mid_rvalid_3", {31'b0, f_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/im_port_arb.md
# im_port_arb

Arbiter and sequencer for the single-port 1024×32 instruction memory, shared between the CPU fetch stage (read) and the program loader (write).
- Each cycle it grants at most one requester and drives the memory address, write-enable and write data.
- It returns read data to fetch one cycle after grant.
- A wait counter guarantees the loader is never starved by back-to-back fetches.

## Interface
Parameters:
- DEPTH_LOG2, 10, word-address width; memory holds 2^DEPTH_LOG2 words.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader takes priority (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
- f_req  input  1  fetch requests a read.
- f_addr  input  32  fetch byte address (PC).
- f_gnt  output  1  fetch granted this cycle (combinational).
- f_rvalid  output  1  f_rdata holds the word for the fetch granted last cycle.
- f_rdata  output  32  fetched instruction word.
- l_req  input  1  loader requests a write.
- l_addr  input  32  loader byte address.
- l_wdata  input  32  word to write.
- l_gnt  output  1  loader write accepted this cycle (combinational).
- l_done  input  1  loader finished; level, sampled each cycle.
- mem_addr  output  DEPTH_LOG2  word index to memory.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid one cycle after the address (synchronous read).

## Operation
- Word index = addr[DEPTH_LOG2+1:2].
  - addr[1:0] is ignored.
  - Upper bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2 bytes.
- Arbitration, each cycle, in order:
  1. reset low: no grant.
  2. Both requesting and wait_cnt == MAX_WAIT: loader wins.
  3. f_req high: fetch wins.
  4. l_req high: loader wins.
  5. Otherwise: idle.
- wait_cnt (4 bits):
  - Increments when l_req is high and l_gnt is low, saturating at MAX_WAIT.
  - Clears on l_gnt or when l_req is low.
- Memory drive:
  - Fetch grant: mem_addr = fetch index, mem_we = 0.
  - Loader grant: mem_addr = loader index, mem_we = 1, mem_wdata = l_wdata.
  - Idle: mem_we = 0, mem_addr holds its last value.
- Read return: registered flag rd_pend = f_gnt. The next cycle, f_rvalid = rd_pend and f_rdata = mem_rdata while rd_pend is high. f_rdata holds its value otherwise.
- A write followed next cycle by a read of the same index returns the new data; the memory is write-first across cycles.
- l_done has no effect unless IM_BOOT_HOLD_EN is defined.

## Timing
- Reset values: f_gnt=0, l_gnt=0, f_rvalid=0, f_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, wait_cnt=0, rd_pend=0.
- Grant latency: 0 cycles (combinational on req). Read latency: 1 cycle (grant at edge N, f_rvalid high in cycle N+1).
- Fetch throughput: 1 read per cycle when uncontested.
- Under contention: the loader gets at least one grant per MAX_WAIT+1 cycles, and fetch gets at least MAX_WAIT grants between loader grants.
- Reset asserted while a read is pending: rd_pend clears, and no f_rvalid is issued for that read.
- Requesters must hold req, addr and wdata stable until granted.
- Simultaneous f_req and l_req to the same index: the arbitration rules apply; there is no merging.

## Configuration
- IM_BOOT_HOLD_EN defined:
  - Adds FSM state BOOT, entered on reset.
  - In BOOT, f_gnt is forced to 0 and only the loader is served.
  - BOOT → RUN at the first edge where l_done=1. RUN is kept until the next reset.
  - In RUN, the arbitration rules above apply.
- Undefined: no FSM, l_done is ignored, and fetch is eligible from the first cycle after reset.

## Structure
- Shared package im_pkg holds:
  - IM_DEPTH_LOG2 (10).
  - IM_WORD_W (32).
  - The function word_index(addr).
  - Enum boot_state_t {BOOT, RUN}.
- One sub-module, im_starve_cnt: the saturating wait counter.
  - Inputs: req, gnt.
  - Output: at_max.
  - Parameter: MAX_WAIT.
- Everything else lives in im_port_arb.

## Test plan
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with f_req=1 and l_req=1.
  - Required: f_gnt, l_gnt, mem_we and f_rvalid stay 0, and f_rdata=0.
- Load then fetch:
  - Stimulus: loader writes 0x3C010000 to byte address 0x00003000, then fetch requests f_addr=0x00003000 the next cycle.
  - Required: f_rvalid=1 one cycle after f_gnt, with f_rdata=0x3C010000 (mem_addr=0x000).
- Starvation guard (MAX_WAIT=4):
  - Stimulus: f_req and l_req held high continuously.
  - Required: fetch is granted cycles 0–3, the loader in cycle 4, then fetch in cycles 5–8, and the pattern repeats.
- Address handling:
  - Stimulus: f_addr=0x00001007, then f_addr=0x00004004.
  - Required: mem_addr=0x001 for both.
- Reset mid-read:
  - Stimulus: f_gnt in cycle N, then reset=0 at edge N+1.
  - Required: f_rvalid stays 0.
- IM_BOOT_HOLD_EN:
  - Stimulus: f_req=1 from reset release, and the loader writes 2 words, then raises l_done.
  - Required: f_gnt=0 until the cycle after l_done=1, then f_gnt=1.
